// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with stall, flush, exception merge and stall counter
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int N_DATA = 3,
    parameter int EXC_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        instr_in,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [N_DATA*DATA_W-1:0] data_in,
    input  logic [4:0]               wba_in,
    input  logic [EXC_W-1:0]         exc_in,
    input  logic [EXC_W-1:0]         exc_local,
    input  logic                     bd_in,
    output logic                     valid_out,
    output logic [DATA_W-1:0]        instr_out,
    output logic [DATA_W-1:0]        pc_out,
    output logic [DATA_W-1:0]        pc8_out,
    output logic [N_DATA*DATA_W-1:0] data_out,
    output logic [4:0]               wba_out,
    output logic [EXC_W-1:0]         exc_out,
    output logic                     bd_out,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Declaration initialisers keep outputs at zero before the first reset.
    logic                     valid_q = 1'b0;
    logic [DATA_W-1:0]        instr_q = '0;
    logic [DATA_W-1:0]        pc_q    = '0;
    logic [DATA_W-1:0]        pc8_q   = '0;
    logic [N_DATA*DATA_W-1:0] data_q  = '0;
    logic [4:0]               wba_q   = '0;
    logic [EXC_W-1:0]         exc_q   = '0;
    logic                     bd_q    = 1'b0;
    logic [CNT_W-1:0]         cnt_q   = '0;

    logic                     valid_d;
    logic [DATA_W-1:0]        instr_d;
    logic [DATA_W-1:0]        pc_d;
    logic [DATA_W-1:0]        pc8_d;
    logic [N_DATA*DATA_W-1:0] data_d;
    logic [4:0]               wba_d;
    logic [EXC_W-1:0]         exc_d;
    logic                     bd_d;
    logic [CNT_W-1:0]         cnt_d;

    logic [EXC_W-1:0]         exc_merged;
    logic [DATA_W-1:0]        pc_plus8;

    always_comb begin
        exc_merged = (exc_in != '0) ? exc_in : exc_local;
        pc_plus8   = pc_in + DATA_W'(8);

        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        data_d  = data_q;
        wba_d   = wba_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        cnt_d   = '0;

        if (flush) begin
            // Bubble, but the faulting PC/BD stay visible for CP0.
            valid_d = 1'b0;
            instr_d = '0;
            data_d  = '0;
            wba_d   = '0;
            exc_d   = '0;
            pc_d    = pc_in;
            pc8_d   = pc_plus8;
            bd_d    = bd_in;
        end else if (stall) begin
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            valid_d = valid_in;
            instr_d = instr_in;
            pc_d    = pc_in;
            pc8_d   = pc_plus8;
            data_d  = data_in;
            bd_d    = bd_in;
            exc_d   = valid_in ? exc_merged : '0;
            wba_d   = (valid_in && exc_merged == '0) ? wba_in : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            pc8_q   <= '0;
            data_q  <= '0;
            wba_q   <= '0;
            exc_q   <= '0;
            bd_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc8_q   <= pc8_d;
            data_q  <= data_d;
            wba_q   <= wba_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_out = valid_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign pc8_out   = pc8_q;
    assign data_out  = data_q;
    assign wba_out   = wba_q;
    assign exc_out   = exc_q;
    assign bd_out    = bd_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [95:0] data;
        logic [4:0]  wba;
        logic [4:0]  exc;
        logic        bd;
        logic [7:0]  cnt;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, flush = 1'b0, valid_in = 1'b0, bd_in = 1'b0;
    logic [31:0] instr_in = '0, pc_in = '0;
    logic [95:0] data_in = '0;
    logic [4:0]  wba_in = '0, exc_in = '0, exc_local = '0;
    logic        valid_out, bd_out;
    logic [31:0] instr_out, pc_out, pc8_out;
    logic [95:0] data_out;
    logic [4:0]  wba_out, exc_out;
    logic [7:0]  stall_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    out_t exp_q[$];

    localparam logic [95:0] DA = {32'hCAFE0003, 32'hBEEF0002, 32'hDEAD0001};
    localparam logic [95:0] DB = {32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF};
    localparam logic [95:0] DC = {32'h00000000, 32'h80000000, 32'h00000001};

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in), .data_in(data_in),
        .wba_in(wba_in), .exc_in(exc_in), .exc_local(exc_local), .bd_in(bd_in),
        .valid_out(valid_out), .instr_out(instr_out), .pc_out(pc_out), .pc8_out(pc8_out),
        .data_out(data_out), .wba_out(wba_out), .exc_out(exc_out), .bd_out(bd_out),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] pc8, input logic [95:0] d, input logic [4:0] w,
                                input logic [4:0] e, input logic b, input logic [7:0] c);
        out_t o;
        o.name = ""; o.v = v; o.instr = ins; o.pc = pc; o.pc8 = pc8; o.data = d;
        o.wba = w; o.exc = e; o.bd = b; o.cnt = c;
        return o;
    endfunction

    task automatic compare(input out_t e);
        n_checks++;
        if (valid_out !== e.v || instr_out !== e.instr || pc_out !== e.pc || pc8_out !== e.pc8 ||
            data_out !== e.data || wba_out !== e.wba || exc_out !== e.exc || bd_out !== e.bd ||
            stall_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL %s: got v=%0b ins=%h pc=%h pc8=%h d=%h wba=%0d exc=%0d bd=%0b cnt=%0d; want v=%0b ins=%h pc=%h pc8=%h d=%h wba=%0d exc=%0d bd=%0b cnt=%0d",
                     e.name, valid_out, instr_out, pc_out, pc8_out, data_out, wba_out, exc_out, bd_out, stall_cnt,
                     e.v, e.instr, e.pc, e.pc8, e.data, e.wba, e.exc, e.bd, e.cnt);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge and queue what the next rising edge must produce.
    task automatic cyc(input string nm, input logic r, input logic f, input logic s, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc, input logic [95:0] d,
                       input logic [4:0] w, input logic [4:0] ei, input logic [4:0] el,
                       input logic b, input out_t e);
        @(negedge clk);
        reset = r; flush = f; stall = s; valid_in = v; instr_in = ins; pc_in = pc;
        data_in = d; wba_in = w; exc_in = ei; exc_local = el; bd_in = b;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) compare(exp_q.pop_front());
    end

    initial begin
        out_t z;
        out_t held;
        int   waited;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        #1;
        z.name = "power_on";
        compare(z);

        cyc("reset", 1, 0, 0, 1, 32'h12345678, 32'h9, DA, 5'd3, 5'd2, 5'd1, 1, z);
        cyc("load", 0, 0, 0, 1, 32'h8C410004, 32'h3000, DA, 5'd1, 5'd0, 5'd0, 0,
            mk(1, 32'h8C410004, 32'h3000, 32'h3008, DA, 5'd1, 5'd0, 0, 0));
        cyc("exc_local", 0, 0, 0, 1, 32'h1, 32'h3004, DB, 5'd8, 5'd0, 5'd12, 0,
            mk(1, 32'h1, 32'h3004, 32'h300C, DB, 5'd0, 5'd12, 0, 0));
        cyc("exc_in_wins", 0, 0, 0, 1, 32'h2, 32'h3008, DB, 5'd8, 5'd4, 5'd12, 0,
            mk(1, 32'h2, 32'h3008, 32'h3010, DB, 5'd0, 5'd4, 0, 0));
        cyc("invalid_in", 0, 0, 0, 0, 32'h55, 32'h100, DC, 5'd7, 5'd3, 5'd0, 1,
            mk(0, 32'h55, 32'h100, 32'h108, DC, 5'd0, 5'd0, 1, 0));

        held = mk(1, 32'hAAAA0001, 32'h3010, 32'h3018, DA, 5'd9, 5'd0, 1, 0);
        cyc("load_3010", 0, 0, 0, 1, 32'hAAAA0001, 32'h3010, DA, 5'd9, 5'd0, 5'd0, 1, held);
        for (int k = 1; k <= 300; k++) begin
            held.cnt = (k > 255) ? 8'd255 : 8'(k);
            cyc($sformatf("stall_%0d", k), 0, 0, 1, k[0], 32'(k), 32'h4000 + 32'(k), ~DA,
                5'd3, k[4:0], 5'd7, 0, held);
        end
        cyc("load_after_stall", 0, 0, 0, 1, 32'h11, 32'h3014, DB, 5'd2, 5'd0, 5'd0, 0,
            mk(1, 32'h11, 32'h3014, 32'h301C, DB, 5'd2, 5'd0, 0, 0));

        cyc("flush_stall", 0, 1, 1, 1, 32'h22, 32'h3020, DC, 5'd5, 5'd0, 5'd3, 1,
            mk(0, 0, 32'h3020, 32'h3028, 0, 5'd0, 5'd0, 1, 0));
        cyc("flush_only", 0, 1, 0, 1, 32'h33, 32'h3030, DA, 5'd5, 5'd6, 5'd0, 0,
            mk(0, 0, 32'h3030, 32'h3038, 0, 5'd0, 5'd0, 0, 0));

        held = mk(1, 32'h44, 32'h3040, 32'h3048, DA, 5'd6, 5'd0, 0, 0);
        cyc("load_3040", 0, 0, 0, 1, 32'h44, 32'h3040, DA, 5'd6, 5'd0, 5'd0, 0, held);
        for (int k = 1; k <= 5; k++) begin
            held.cnt = 8'(k);
            cyc($sformatf("pre_reset_stall_%0d", k), 0, 0, 1, 1, 32'h77, 32'h5000, DB, 5'd1, 5'd0, 5'd0, 1, held);
        end
        cyc("reset_mid_stall", 1, 0, 1, 1, 32'h77, 32'h5000, DB, 5'd1, 5'd0, 5'd0, 1, z);
        cyc("wrap_load", 0, 0, 0, 1, 32'h66, 32'hFFFFFFFC, DB, 5'd31, 5'd0, 5'd0, 1,
            mk(1, 32'h66, 32'hFFFFFFFC, 32'h00000004, DB, 5'd31, 5'd0, 1, 0));

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
